// File: rtl/wb_trace_collector.sv
// Architectural write-event trace collector for the mips core.
// GRF and DM commit events go into a first-word-fall-through FIFO that is read over valid/ready.
module wb_trace_collector #(
   parameter int DEPTH      = 16,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             grf_we,
   input  logic [31:0]      grf_pc,
   input  logic [4:0]       grf_addr,
   input  logic [31:0]      grf_wdata,
   input  logic             dm_we,
   input  logic [31:0]      dm_pc,
   input  logic [31:0]      dm_addr,
   input  logic [31:0]      dm_wdata,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic             ev_kind,
   output logic [31:0]      ev_pc,
   output logic [31:0]      ev_addr,
   output logic [31:0]      ev_data,
   output logic             overflow,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [96:0]   slots [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic          grf_ev;
   logic          dm_ev;
   logic          pop;
   logic [AW:0]   free;
   logic          push_grf;
   logic          push_dm;
   logic [AW-1:0] dm_slot;
   logic [96:0]   grf_entry;
   logic [96:0]   dm_entry;
   logic [96:0]   head;

   assign grf_ev    = grf_we && (grf_addr != 5'd0);
   assign dm_ev     = dm_we;
   assign ev_valid  = (count != '0);
   assign pop       = ev_valid && ev_ready;
   assign free      = DEPTH_C - count + {{AW{1'b0}}, pop};

   // GRF takes the first free slot; DM is the younger instruction so it needs the next one.
   assign push_grf  = grf_ev && (free >= (AW+1)'(1));
   assign push_dm   = dm_ev && (free >= (grf_ev ? (AW+1)'(2) : (AW+1)'(1)));
   assign dm_slot   = wr_ptr + AW'(push_grf);

   assign grf_entry = {1'b0, grf_pc, 27'd0, grf_addr, grf_wdata};
   assign dm_entry  = {1'b1, dm_pc, dm_addr, dm_wdata};

   assign head      = slots[rd_ptr];
   assign ev_kind   = head[96];
   assign ev_pc     = head[95:64];
   assign ev_addr   = head[63:32];
   assign ev_data   = head[31:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else begin
         if (push_grf) slots[wr_ptr] <= grf_entry;
         if (push_dm) slots[dm_slot] <= dm_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + AW'(push_grf) + AW'(push_dm);
         count  <= count + (AW+1)'(push_grf) + (AW+1)'(push_dm) - (AW+1)'(pop);
         if ((grf_ev && !push_grf) || (dm_ev && !push_dm)) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt <= '0;
         done      <= 1'b0;
      end else begin
         if (cycle_cnt != {CNT_W{1'b1}}) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
         if (cycle_cnt >= CNT_W'(MAX_CYCLES) && count == '0 && !push_grf && !push_dm) begin
            done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wb_trace_collector.sv
// Self-checking bench for wb_trace_collector against a queue-based event model.
module tb_wb_trace_collector;
   localparam int DEPTH = 16;
   localparam int MAXC  = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        grf_we = 1'b0;
   logic [31:0] grf_pc = '0;
   logic [4:0]  grf_addr = '0;
   logic [31:0] grf_wdata = '0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_pc = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic        ev_ready = 1'b0;
   logic        ev_valid;
   logic        ev_kind;
   logic [31:0] ev_pc;
   logic [31:0] ev_addr;
   logic [31:0] ev_data;
   logic        overflow;
   logic [31:0] cycle_cnt;
   logic        done;

   wb_trace_collector #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
      .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_pc(ev_pc),
      .ev_addr(ev_addr), .ev_data(ev_data), .overflow(overflow),
      .cycle_cnt(cycle_cnt), .done(done)
   );

   always #5 clk = ~clk;

   logic [96:0] q[$];
   logic        m_ovf;
   logic        m_done;
   int          m_cyc;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [96:0] last_pop;

   function automatic logic [96:0] obs();
      return {ev_kind, ev_pc, ev_addr, ev_data};
   endfunction

   task automatic do_reset();
      grf_we = 0; dm_we = 0; ev_ready = 0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete(); m_ovf = 0; m_done = 0; m_cyc = 0;
   endtask

   // Drive one cycle of inputs, advance the model by the same edge, sample 1 ns after it.
   task automatic tick(input logic gwe, input logic [31:0] gpc, input logic [4:0] ga,
                       input logic [31:0] gd, input logic dwe, input logic [31:0] dpc,
                       input logic [31:0] da, input logic [31:0] dd, input logic rdy);
      bit pop, gev, any_push;
      int avail;
      grf_we = gwe; grf_pc = gpc; grf_addr = ga; grf_wdata = gd;
      dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_wdata = dd; ev_ready = rdy;
      pop   = (q.size() != 0) && rdy;
      avail = DEPTH - q.size() + (pop ? 1 : 0);
      gev   = gwe && (ga != 0);
      any_push = 0;
      if (pop) last_pop = q.pop_front();
      if (gev) begin
         if (avail > 0) begin
            q.push_back({1'b0, gpc, {27'd0, ga}, gd}); avail--; any_push = 1;
         end else m_ovf = 1;
      end
      if (dwe) begin
         if (avail > 0) begin
            q.push_back({1'b1, dpc, da, dd}); avail--; any_push = 1;
         end else m_ovf = 1;
      end
      if (m_cyc >= MAXC && (q.size() - (any_push ? 1 : 0) + (pop ? 1 : 0)) == 0 && !any_push)
         m_done = 1;
      m_cyc++;
      @(posedge clk); #1;
      grf_we = 0; dm_we = 0;
   endtask

   task automatic idle(input logic rdy);
      tick(0, 0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ev_valid); end
      n_checks++; if (obs() !== 97'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", obs()); end
      n_checks++; if ({overflow, done, cycle_cnt} !== 34'd0) begin n_fail++; $display("FAIL reset_flags ovf=%b done=%b cnt=%0d exp=0/0/0", overflow, done, cycle_cnt); end
      for (int i = 0; i < 5; i++) tick(1, 32'h100 + i*4, 5'(i + 1), $urandom, 0, 0, 0, 0, 0);
      n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL reset_prefill got=%b exp=1", ev_valid); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({ev_valid, overflow, cycle_cnt} !== 34'd0) begin n_fail++; $display("FAIL reset_async valid=%b ovf=%b cnt=%0d exp=0/0/0", ev_valid, overflow, cycle_cnt); end
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete(); m_ovf = 0; m_done = 0; m_cyc = 0;
      tick(1, 32'h200, 5'd3, 32'h55, 0, 0, 0, 0, 0);
      n_checks++; if (ev_valid !== 1'b1 || obs() !== q[0]) begin n_fail++; $display("FAIL reset_repush valid=%b got=%h exp=%h", ev_valid, obs(), q[0]); end
      idle(1);
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_one_entry got=%b exp=0", ev_valid); end
   endtask

   task automatic test_single_grf();
      do_reset();
      tick(1, 32'h3000, 5'd8, 32'h1234, 0, 0, 0, 0, 1);
      n_checks++; if ({ev_valid, ev_kind, ev_pc, ev_addr, ev_data} !== {1'b1, 1'b0, 32'h3000, 32'h8, 32'h1234})
         begin n_fail++; $display("FAIL single_grf got=%b/%b/%h/%h/%h exp=1/0/3000/8/1234", ev_valid, ev_kind, ev_pc, ev_addr, ev_data); end
      idle(1);
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_grf_pop got=%b exp=0", ev_valid); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      tick(1, 32'h3004, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0);
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL zero_reg got=%b exp=0", ev_valid); end
   endtask

   task automatic test_dual();
      do_reset();
      tick(1, 32'h3010, 5'd9, 32'h99, 1, 32'h3014, 32'h10, 32'hAB, 1);
      n_checks++; if ({ev_valid, obs()} !== {1'b1, 1'b0, 32'h3010, 32'h9, 32'h99})
         begin n_fail++; $display("FAIL dual_first valid=%b got=%h", ev_valid, obs()); end
      idle(1);
      n_checks++; if ({ev_valid, obs()} !== {1'b1, 1'b1, 32'h3014, 32'h10, 32'hAB})
         begin n_fail++; $display("FAIL dual_second valid=%b got=%h", ev_valid, obs()); end
      idle(1);
      n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL dual_empty got=%b exp=0", ev_valid); end
   endtask

   task automatic test_full();
      int guard;
      do_reset();
      for (int i = 0; i < DEPTH; i++) tick(1, 32'h400 + i*4, 5'(i % 31 + 1), $urandom, 0, 0, 0, 0, 0);
      tick(1, 32'h500, 5'd7, 32'h77, 0, 0, 0, 0, 1);
      n_checks++; if (overflow !== 1'b0 || ev_valid !== 1'b1) begin n_fail++; $display("FAIL full_pushpop ovf=%b valid=%b exp=0/1", overflow, ev_valid); end
      tick(1, 32'h504, 5'd6, 32'h66, 0, 0, 0, 0, 0);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow got=%b exp=1", overflow); end
      tick(1, 32'h600, 5'd5, 32'hCAFE, 1, 32'h604, 32'h20, 32'hBEEF, 1);
      guard = 0;
      while (q.size() != 0 && guard < 40) begin
         n_checks++; if (ev_valid !== 1'b1 || obs() !== q[0]) begin n_fail++; $display("FAIL full_drain valid=%b got=%h exp=%h", ev_valid, obs(), q[0]); end
         idle(1);
         guard++;
      end
      n_checks++; if (last_pop !== {1'b0, 32'h600, 32'h5, 32'hCAFE} || ev_valid !== 1'b0)
         begin n_fail++; $display("FAIL full_last got=%h valid=%b exp=grf pc 600 then empty", last_pop, ev_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1), $urandom, {$urandom_range(0, 255), 2'b00}, $urandom,
              $urandom_range(0, 3) == 0 ? 1'b0 : 1'b1);
         n_checks++;
         if (ev_valid !== (q.size() != 0) || (q.size() != 0 && obs() !== q[0]) ||
             overflow !== m_ovf || cycle_cnt !== 32'(m_cyc)) begin
            n_fail++;
            $display("FAIL random_%0d valid=%b got=%h ovf=%b cnt=%0d exp valid=%b head=%h ovf=%b cnt=%0d",
                     i, ev_valid, obs(), overflow, cycle_cnt, q.size() != 0,
                     q.size() != 0 ? q[0] : 97'd0, m_ovf, m_cyc);
         end
      end
   endtask

   task automatic test_done();
      do_reset();
      for (int i = 0; i < 3; i++) tick(1, 32'h700 + i*4, 5'(i + 1), $urandom, 0, 0, 0, 0, 0);
      while (m_cyc < 30) idle(0);
      n_checks++; if (done !== 1'b0 || ev_valid !== 1'b1) begin n_fail++; $display("FAIL done_held done=%b valid=%b exp=0/1", done, ev_valid); end
      for (int i = 0; i < 6; i++) begin
         idle(1);
         n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL done_drain_%0d got=%b exp=%b", i, done, m_done); end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_set got=%b exp=1", done); end
      tick(1, 32'h800, 5'd4, 32'h44, 0, 0, 0, 0, 0);
      n_checks++; if (done !== 1'b1 || ev_valid !== 1'b1 || cycle_cnt !== 32'(m_cyc))
         begin n_fail++; $display("FAIL done_sticky done=%b valid=%b cnt=%0d exp=1/1/%0d", done, ev_valid, cycle_cnt, m_cyc); end
   endtask

   initial begin
      test_reset();
      test_single_grf();
      test_zero_reg();
      test_dual();
      test_full();
      test_random();
      test_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
